// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO station-management controller: clause-22
// opcodes, frame lengths and the controller state enumeration.
// Optional feature macro: MDIO_PREAMBLE_EN adds the PREAMBLE state.
package mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] ST_C22   = 2'b01;

  localparam int FRAME_BITS    = 32;
  localparam int PREAMBLE_BITS = 32;

`ifdef MDIO_PREAMBLE_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_FRAME
  } mdio_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME
  } mdio_state_t;
`endif

endpackage

// File: rtl/mdio_controller_mdc_gen.sv
// MDC divider: MDC is low for CLK_DIV cycles then high for CLK_DIV cycles
// while enabled. mdc_rise / mdc_fall are high in the CLK cycle at whose end
// MDC changes, so logic clocked on that edge sees the new half-period begin.
module mdc_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);
  import mdio_pkg::*;

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last  = (cnt == LAST);
  assign mdc_rise = en && !mdc && at_last;
  assign mdc_fall = en &&  mdc && at_last;

  // Half-period counter; held at zero with MDC low whenever disabled.
  always_ff @(posedge CLK) begin
    if (rst || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (at_last) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_controller.sv
// MDIO station-management master: serialises a clause-22 frame word MSB first
// onto MDIO, releases the line for the turnaround and data of read frames and
// captures the 16 bits the PHY returns.
// Optional feature macro: MDIO_PREAMBLE_EN prefixes every frame with 32 ones.
module mdio_controller #(
  parameter int CLK_DIV = 1
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);
  import mdio_pkg::*;

  localparam logic [4:0] LAST_BIT    = 5'(FRAME_BITS - 1);
  localparam logic [4:0] LAST_DRIVEN = 5'd13;  // read: last bit before release
  localparam logic [4:0] FIRST_RX    = 5'd16;  // read: first returned data bit
`ifdef MDIO_PREAMBLE_EN
  localparam logic [4:0] LAST_PRE    = 5'(PREAMBLE_BITS - 1);
`endif

  mdio_state_t state;
  logic [4:0]  bit_cnt;
  logic [31:0] tx_shift;   // bit [31] is always the next bit to put on MDIO
  logic [15:0] rx_shift;
  logic        is_read;
  logic        mdc_rise;
  logic        mdc_fall;

  mdc_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_mdc_gen (
    .CLK      (CLK),
    .rst      (rst),
    .en       (BUSY),
    .mdc      (MDC),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  // Frame sequencer: outputs are registered and MDIO_OUT only moves on the
  // edge that drops MDC, giving a full half-period of setup and hold.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      is_read  <= 1'b0;
      rx_shift <= '0;
      BUSY     <= 1'b0;
      MDIO_OE  <= 1'b0;
      MDIO_OUT <= 1'b0;
      RD_DATA  <= '0;
      DATA_RDY <= 1'b0;
    end else begin
      DATA_RDY <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MDIO_START) begin
            is_read <= (T_DATA[29:28] == OP_READ);
            bit_cnt <= '0;
            BUSY    <= 1'b1;
            MDIO_OE <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
            tx_shift <= T_DATA;
            MDIO_OUT <= 1'b1;
            state    <= ST_PREAMBLE;
`else
            tx_shift <= {T_DATA[30:0], 1'b0};
            MDIO_OUT <= T_DATA[31];
            state    <= ST_FRAME;
`endif
          end
        end
`ifdef MDIO_PREAMBLE_EN
        ST_PREAMBLE: begin
          if (mdc_fall) begin
            if (bit_cnt == LAST_PRE) begin
              bit_cnt  <= '0;
              MDIO_OUT <= tx_shift[31];
              tx_shift <= {tx_shift[30:0], 1'b0};
              state    <= ST_FRAME;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
`endif
        ST_FRAME: begin
          if (mdc_rise && is_read && (bit_cnt >= FIRST_RX)) begin
            rx_shift <= {rx_shift[14:0], MDIO_IN};
          end
          if (mdc_fall) begin
            if (bit_cnt == LAST_BIT) begin
              BUSY     <= 1'b0;
              MDIO_OE  <= 1'b0;
              MDIO_OUT <= 1'b0;
              state    <= ST_IDLE;
              if (is_read) begin
                RD_DATA  <= rx_shift;
                DATA_RDY <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              tx_shift <= {tx_shift[30:0], 1'b0};
              if (is_read && (bit_cnt >= LAST_DRIVEN)) begin
                MDIO_OE  <= 1'b0;
                MDIO_OUT <= 1'b0;
              end else begin
                MDIO_OUT <= tx_shift[31];
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_controller.sv
// Directed bench for mdio_controller: one instance with CLK_DIV=1 and one
// with CLK_DIV=3. Cycle numbering: the start is presented in cycle 0 and
// values are sampled 1 time unit after each rising edge.
module tb_mdio_controller;
  import mdio_pkg::*;

  localparam int D3 = 3;
`ifdef MDIO_PREAMBLE_EN
  localparam int PRE1 = 64;
  localparam int PRE3 = 64 * D3;
`else
  localparam int PRE1 = 0;
  localparam int PRE3 = 0;
`endif

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic [31:0] tdata1 = '0;
  logic        phy_in = 1'b0;
  logic        mdc1, out1, oe1, rdy1, busy1;
  logic [15:0] rd1;
  logic        start3 = 1'b0;
  logic [31:0] tdata3 = '0;
  logic        phy_in3 = 1'b0;
  logic        mdc3, out3, oe3, rdy3, busy3;
  logic [15:0] rd3;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  mdio_controller #(.CLK_DIV(1)) dut (
    .CLK(CLK), .rst(rst), .MDIO_START(start1), .T_DATA(tdata1), .MDIO_IN(phy_in),
    .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1), .RD_DATA(rd1), .DATA_RDY(rdy1), .BUSY(busy1)
  );

  mdio_controller #(.CLK_DIV(D3)) dut3 (
    .CLK(CLK), .rst(rst), .MDIO_START(start3), .T_DATA(tdata3), .MDIO_IN(phy_in3),
    .MDC(mdc3), .MDIO_OUT(out3), .MDIO_OE(oe3), .RD_DATA(rd3), .DATA_RDY(rdy3), .BUSY(busy3)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    total++; if (mdc1 !== 1'b0) begin bad++; $display("FAIL reset_mdc got=%b want=0", mdc1); end
    total++; if (out1 !== 1'b0) begin bad++; $display("FAIL reset_out got=%b want=0", out1); end
    total++; if (oe1 !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", oe1); end
    total++; if (rd1 !== 16'h0000) begin bad++; $display("FAIL reset_rd got=%h want=0000", rd1); end
    total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", rdy1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy1); end
    total++; if (mdc3 !== 1'b0 || busy3 !== 1'b0 || oe3 !== 1'b0 || out3 !== 1'b0)
      begin bad++; $display("FAIL reset_div3 mdc=%b busy=%b oe=%b out=%b want all 0", mdc3, busy3, oe3, out3); end
    rst = 1'b0;
    tick();
    total++; if (busy1 !== 1'b0 || mdc1 !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b mdc=%b want 0", busy1, mdc1); end
  endtask

  task automatic test_write;
    logic [31:0] word;
    logic [31:0] cap;
    logic        prev_mdc;
    int          e;
    int          p;
    word = 32'h5AA2_BEEF;
    tdata1 = word; start1 = 1'b1;
    tick();
    start1 = 1'b0; tdata1 = '0;
    cap = '0; prev_mdc = 1'b0;
    for (int c = 1; c <= 64 + PRE1; c++) begin
      e = c - PRE1;
      total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL wr_busy cyc=%0d got=%b want=1", c, busy1); end
      total++; if (oe1 !== 1'b1) begin bad++; $display("FAIL wr_oe cyc=%0d got=%b want=1", c, oe1); end
      total++; if (mdc1 !== (((c - 1) % 2) == 1)) begin bad++; $display("FAIL wr_mdc cyc=%0d got=%b", c, mdc1); end
      if (e > 0) begin
        p = (e - 1) / 2;
        total++; if (out1 !== word[31 - p]) begin bad++; $display("FAIL wr_bit cyc=%0d got=%b want=%b", c, out1, word[31 - p]); end
        if (mdc1 && !prev_mdc) cap = {cap[30:0], out1};
      end else begin
        total++; if (out1 !== 1'b1) begin bad++; $display("FAIL wr_preamble cyc=%0d got=%b want=1", c, out1); end
      end
      prev_mdc = mdc1;
      tick();
    end
    total++; if (cap !== word) begin bad++; $display("FAIL wr_stream got=%h want=%h", cap, word); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL wr_end_busy got=%b want=0", busy1); end
    total++; if (oe1 !== 1'b0 || mdc1 !== 1'b0) begin bad++; $display("FAIL wr_end_line oe=%b mdc=%b want 0", oe1, mdc1); end
    total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL wr_no_rdy got=%b want=0", rdy1); end
    tick();
  endtask

  task automatic test_read;
    logic [31:0] word;
    logic [15:0] rdv;
    int          e;
    int          p;
    int          oe_fall;
    word = {ST_C22, OP_READ, 5'b10101, 5'b00000, 2'b00, 16'h0000};
    rdv = 16'hC3A5;
    total++; if (word !== 32'h6A80_0000) begin bad++; $display("FAIL rd_word got=%h want=6a800000", word); end
    tdata1 = word; start1 = 1'b1;
    tick();
    start1 = 1'b0; tdata1 = '0;
    oe_fall = -1;
    for (int c = 1; c <= 64 + PRE1; c++) begin
      e = c - PRE1;
      p = (e > 0) ? (e - 1) / 2 : -1;
      if (p >= 16) phy_in = rdv[31 - p];
      else phy_in = 1'b0;
      if (oe1 === 1'b0 && oe_fall < 0) oe_fall = c;
      total++; if (busy1 !== 1'b1 || rdy1 !== 1'b0) begin bad++; $display("FAIL rd_busy cyc=%0d busy=%b rdy=%b want 1/0", c, busy1, rdy1); end
      if (e > 0 && p < 14) begin
        total++; if (oe1 !== 1'b1 || out1 !== word[31 - p]) begin bad++; $display("FAIL rd_drive cyc=%0d oe=%b out=%b want 1/%b", c, oe1, out1, word[31 - p]); end
      end else if (p >= 14) begin
        total++; if (oe1 !== 1'b0 || out1 !== 1'b0) begin bad++; $display("FAIL rd_release cyc=%0d oe=%b out=%b want 0/0", c, oe1, out1); end
      end
      tick();
    end
    phy_in = 1'b0;
    total++; if (oe_fall !== PRE1 + 29) begin bad++; $display("FAIL rd_oe_fall got=%0d want=%0d", oe_fall, PRE1 + 29); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rd_rdy got=%b want=1", rdy1); end
    total++; if (rd1 !== rdv) begin bad++; $display("FAIL rd_data got=%h want=%h", rd1, rdv); end
    total++; if (busy1 !== 1'b0 || mdc1 !== 1'b0 || oe1 !== 1'b0) begin bad++; $display("FAIL rd_end busy=%b mdc=%b oe=%b want 0", busy1, mdc1, oe1); end
    tick();
    total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL rd_rdy_single got=%b want=0", rdy1); end
    total++; if (rd1 !== rdv) begin bad++; $display("FAIL rd_data_hold got=%h want=%h", rd1, rdv); end
  endtask

  task automatic test_divider;
    logic [31:0] word;
    logic        prev_mdc;
    logic        prev_out;
    int          changes;
    int          e;
    word = {ST_C22, OP_WRITE, 5'd0, 5'd1, 2'b10, 16'h1234};
    tdata3 = word; start3 = 1'b1;
    tick();
    start3 = 1'b0; tdata3 = '0;
    changes = 0; prev_mdc = 1'b0; prev_out = out3;
    for (int c = 1; c <= 192 + PRE3; c++) begin
      e = c - PRE3;
      total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL div_busy cyc=%0d got=%b want=1", c, busy3); end
      total++; if (mdc3 !== (((c - 1) % 6) >= 3)) begin bad++; $display("FAIL div_mdc cyc=%0d got=%b", c, mdc3); end
      if (e > 0) begin
        total++; if (out3 !== word[31 - (e - 1) / 6]) begin bad++; $display("FAIL div_bit cyc=%0d got=%b want=%b", c, out3, word[31 - (e - 1) / 6]); end
      end
      if (mdc3 && prev_mdc && out3 !== prev_out) changes++;
      prev_mdc = mdc3; prev_out = out3;
      tick();
    end
    total++; if (changes !== 0) begin bad++; $display("FAIL div_stable_high got=%0d changes want=0", changes); end
    total++; if (busy3 !== 1'b0 || mdc3 !== 1'b0 || oe3 !== 1'b0) begin bad++; $display("FAIL div_end busy=%b mdc=%b oe=%b want 0", busy3, mdc3, oe3); end
    tick();
  endtask

  task automatic test_ignored_start;
    logic [31:0] word;
    logic [31:0] bb;
    int          e;
    word = 32'h5003_0F0F;
    bb = 32'hD000_0000;
    tdata1 = word; start1 = 1'b1;
    tick();
    start1 = 1'b0; tdata1 = '0;
    for (int c = 1; c <= 64 + PRE1; c++) begin
      e = c - PRE1;
      if (c == 10) begin start1 = 1'b1; tdata1 = 32'hFFFF_FFFF; end
      else begin start1 = 1'b0; tdata1 = '0; end
      total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL ign_busy cyc=%0d got=%b want=1", c, busy1); end
      if (e > 0) begin
        total++; if (out1 !== word[31 - (e - 1) / 2]) begin bad++; $display("FAIL ign_bit cyc=%0d got=%b want=%b", c, out1, word[31 - (e - 1) / 2]); end
      end
      tick();
    end
    total++; if (busy1 !== 1'b0 || mdc1 !== 1'b0) begin bad++; $display("FAIL ign_end busy=%b mdc=%b want 0", busy1, mdc1); end
    // back-to-back start presented in the first idle cycle
    tdata1 = bb; start1 = 1'b1;
    tick();
    start1 = 1'b0; tdata1 = '0;
    total++; if (busy1 !== 1'b1 || oe1 !== 1'b1 || mdc1 !== 1'b0 || out1 !== 1'b1)
      begin bad++; $display("FAIL b2b_start busy=%b oe=%b mdc=%b out=%b want 1/1/0/1", busy1, oe1, mdc1, out1); end
    repeat (64 + PRE1) tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_end busy got=%b want=0", busy1); end
    tick();
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] word;
    logic [31:0] word2;
    logic [31:0] cap;
    logic        prev_mdc;
    int          rdy_seen;
    int          e;
    word = 32'h6A80_0000;
    word2 = 32'h5AA2_BEEF;
    tdata1 = word; start1 = 1'b1;
    tick();
    start1 = 1'b0; tdata1 = '0;
    rdy_seen = 0;
    for (int c = 1; c < 40; c++) begin
      phy_in = c[0];
      if (rdy1 !== 1'b0) rdy_seen++;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; phy_in = 1'b0;
    total++; if (mdc1 !== 1'b0 || oe1 !== 1'b0) begin bad++; $display("FAIL rst_mid_line mdc=%b oe=%b want 0", mdc1, oe1); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy1); end
    total++; if (rd1 !== 16'h0000) begin bad++; $display("FAIL rst_mid_rd got=%h want=0000", rd1); end
    for (int c = 0; c < 40; c++) begin
      if (rdy1 !== 1'b0 || busy1 !== 1'b0) rdy_seen++;
      tick();
    end
    total++; if (rdy_seen !== 0) begin bad++; $display("FAIL rst_mid_no_rdy got=%0d events want=0", rdy_seen); end
    tdata1 = word2; start1 = 1'b1;
    tick();
    start1 = 1'b0; tdata1 = '0;
    total++; if (busy1 !== 1'b1 || oe1 !== 1'b1 || mdc1 !== 1'b0) begin bad++; $display("FAIL restart_first busy=%b oe=%b mdc=%b want 1/1/0", busy1, oe1, mdc1); end
    total++; if (out1 !== ((PRE1 > 0) ? 1'b1 : word2[31])) begin bad++; $display("FAIL restart_bit31 got=%b", out1); end
    cap = '0; prev_mdc = 1'b0;
    for (int c = 1; c <= 64 + PRE1; c++) begin
      e = c - PRE1;
      if (e > 0 && mdc1 && !prev_mdc) cap = {cap[30:0], out1};
      prev_mdc = mdc1;
      tick();
    end
    total++; if (cap !== word2) begin bad++; $display("FAIL restart_stream got=%h want=%h", cap, word2); end
    total++; if (busy1 !== 1'b0 || rdy1 !== 1'b0) begin bad++; $display("FAIL restart_end busy=%b rdy=%b want 0", busy1, rdy1); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_divider();
    test_ignored_start();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_controller.md
# mdio_controller

Station-management (master) side of the MDIO link: accepts a 32-bit clause-22 frame word from the host, generates MDC and serialises the frame onto MDIO, and for read frames releases the line and captures the 16 data bits returned by the `receptor`. It is the other end of the `receptor` block's MDIO interface; `MDC`, `MDIO_OE`, `MDIO_OUT` and `MDIO_IN` connect directly to that block.

## Interface
- `CLK_DIV`, default 1: number of CLK cycles per MDC half-period. The minimum legal value is 1. The MDC period is 2·CLK_DIV CLK cycles.
- `CLK` input 1: system clock. All logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `MDIO_START` input 1: request a transaction. It is sampled only in IDLE.
- `T_DATA` input 32: frame word. [31:30]=ST, [29:28]=OP, [27:23]=PHYAD, [22:18]=REGAD, [17:16]=TA, [15:0]=data. It is latched on an accepted start.
- `MDIO_IN` input 1: serial data driven back by the PHY.
- `MDC` output 1: management clock. It idles low.
- `MDIO_OUT` output 1: serial data, MSB first.
- `MDIO_OE` output 1: high while the controller drives MDIO.
- `RD_DATA` output 16: captured read data.
- `DATA_RDY` output 1: single-cycle pulse when `RD_DATA` is valid.
- `BUSY` output 1: high from the cycle after a start is accepted until the frame ends.

## Operation
- **Reset values:** MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, BUSY=0. The state returns to IDLE and the divider is cleared.
- **States:** IDLE → PREAMBLE (only when the macro is defined) → FRAME → IDLE.
- **IDLE:**
  - If MDIO_START=1, latch T_DATA and go to the first bit.
  - START pulses while BUSY=1 are ignored and not queued.
- **Frame type:**
  - OP==2'b10 is a read. Any other OP is transmitted as a write-style frame, with all 32 bits driven.
- **Write frame:** 32 bit periods, with MDIO_OE=1 throughout.
- **Read frame:**
  - Bits 31..18 (14 periods) are driven with MDIO_OE=1.
  - For the remaining 18 periods (TA plus 16 data bits), MDIO_OE=0 and MDIO_OUT=0.
- **Bit shift:** a bit counter and a 32-bit shift register advance once per MDC period.
- **Read capture:**
  - MDIO_IN is sampled in the CLK cycle in which MDC transitions 0→1, during bit periods 16..31.
  - Bits are shifted into RD_DATA MSB first.
- **End of frame:** when the final falling MDC edge of bit 31 occurs, the controller enters IDLE. For reads it then pulses DATA_RDY.
- **Reset mid-frame:** the frame is abandoned at the next edge, with reset values and no DATA_RDY pulse. RD_DATA is cleared.

## Timing
- Let a start be accepted at cycle 0.
- Bit n occupies cycles 1+2n·CLK_DIV through 2(n+1)·CLK_DIV.
- Within each bit:
  - MDC is low for the first CLK_DIV cycles and high for the second CLK_DIV cycles.
  - MDIO_OUT changes only on the cycle in which MDC goes low, or on the first cycle of the frame. This gives a full half-period of setup and hold around the MDC rising edge, where the `receptor` samples.
- With CLK_DIV=1 and no preamble:
  - BUSY is high in cycles 1..64.
  - IDLE is entered at cycle 65, with MDIO_OE=0 and MDC=0.
  - For reads, RD_DATA is updated and DATA_RDY=1 in cycle 65 only.
- The preamble adds 64·CLK_DIV cycles before bit 31.
- Back-to-back frames: a START present in the first IDLE cycle is accepted. The minimum gap between frames is one CLK cycle of MDC low.
- Divider:
  - The counter is $clog2(CLK_DIV)+1 bits wide and counts 0..CLK_DIV-1 before toggling MDC.
  - It is held at 0 in IDLE.

## Configuration
- `MDIO_PREAMBLE_EN` defined:
  - Every frame is preceded by 32 MDC periods with MDIO_OUT=1 and MDIO_OE=1.
  - BUSY covers the preamble.
- Not defined:
  - The PREAMBLE state is not compiled in, and frames start directly with ST (preamble suppression).

## Structure
- Package `mdio_pkg` holds:
  - OP_READ=2'b10, OP_WRITE=2'b01, ST_C22=2'b01.
  - FRAME_BITS=32 and PREAMBLE_BITS=32.
  - The controller state enumeration.
- Sub-module `mdc_gen`:
  - Divider producing MDC and the one-cycle `mdc_rise` and `mdc_fall` strobes used by the shifter and sampler.
  - Enabled by BUSY.

## Test plan
- **Write frame (macro off, CLK_DIV=1):** START with T_DATA=32'h5AA2_BEEF.
  - MDIO_OUT must carry 0101_1010_1010_0010_1011_1110_1110_1111 on 32 consecutive MDC rising edges.
  - MDIO_OE=1 in cycles 1..64.
  - In a loopback with `receptor`: WR_STB fires, ADDR matches REGAD, and WR_DATA=16'hBEEF.
- **Read frame:** T_DATA=32'h6A80_0000 with the PHY returning 16'hC3A5.
  - MDIO_OE falls after 14 bits.
  - RD_DATA=16'hC3A5 and DATA_RDY is high for exactly one cycle at cycle 65.
- **Divider (CLK_DIV=3):** MDC period is 6 CLK cycles. A write frame holds BUSY for 192 cycles, and MDIO_OUT never changes while MDC=1.
- **Preamble (`MDIO_PREAMBLE_EN` defined):** 32 ones precede ST. BUSY is high for 128 cycles with CLK_DIV=1.
- **Ignored start:** a second START in cycle 10 of a write has no effect. Exactly one frame is emitted and BUSY returns low at cycle 65.
- **Reset mid-read:** rst asserted at cycle 40.
  - At cycle 41: MDC=0, MDIO_OE=0, BUSY=0, RD_DATA=0.
  - No DATA_RDY pulse occurs.
  - A subsequent START restarts cleanly from bit 31.
